// File: rtl/multicycle_cu_if.sv
// rtl/multicycle_cu_if.sv - datapath-side signal bundle for multicycle_cu
// The illegal line exists only when CU_ILLEGAL_TRAP_EN is defined.
interface multicycle_cu_if #(
    parameter int RET_W = 16
);
    logic [10:0]      opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_wr;
    logic             ir_wr;
    logic             reg2loc;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             pc_src;
    logic [1:0]       seu;
    logic [2:0]       alu_op;
    logic [2:0]       state;
    logic             mem_err;
    logic [RET_W-1:0] retired;
`ifdef CU_ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    modport master (
`ifdef CU_ILLEGAL_TRAP_EN
        output illegal,
`endif
        input  opcode, zero, mem_ready,
        output pc_wr, ir_wr, reg2loc, alu_src, mem_to_reg, reg_wr, mem_rd, mem_wr,
        output pc_src, seu, alu_op, state, mem_err, retired
    );

    modport slave (
`ifdef CU_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        output opcode, zero, mem_ready,
        input  pc_wr, ir_wr, reg2loc, alu_src, mem_to_reg, reg_wr, mem_rd, mem_wr,
        input  pc_src, seu, alu_op, state, mem_err, retired
    );
endinterface

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multicycle LEGv8 control unit with memory-wait timeout and retire counter
// Optional CU_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP instead of being skipped.
module multicycle_cu #(
    parameter int MAX_WAIT = 8,
    parameter int RET_W    = 16
) (
    input logic             clk,
    input logic             reset,
    multicycle_cu_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI, C_ANDI, C_ORRI,
        C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [7:0]       wait_q, wait_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             timeout;
    logic             pc_wr, ir_wr, reg2loc, alu_src, mem_to_reg, reg_wr, mem_rd, mem_wr, pc_src;
    logic             mem_err, illegal;
    logic [1:0]       seu;
    logic [2:0]       alu_op;

    always_comb begin
        dec_cls = C_ILL;
        casez (bus.opcode)
            11'b10001011000: dec_cls = C_ADD;
            11'b11001011000: dec_cls = C_SUB;
            11'b10001010000: dec_cls = C_AND;
            11'b10101010000: dec_cls = C_ORR;
            11'b1001000100?: dec_cls = C_ADDI;
            11'b1101000100?: dec_cls = C_SUBI;
            11'b1001001000?: dec_cls = C_ANDI;
            11'b1011001000?: dec_cls = C_ORRI;
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b000101?????: dec_cls = C_B;
            11'b10110100???: dec_cls = C_CBZ;
            11'b10110101???: dec_cls = C_CBNZ;
            default:         dec_cls = C_ILL;
        endcase
    end

    // Ready in the last allowed wait cycle still completes; only a missing ready times out.
    assign timeout = (wait_q == WAIT_LAST) && !bus.mem_ready;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_d     = '0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_src     = 1'b0;
        mem_err    = 1'b0;
        illegal    = 1'b0;
        seu        = 2'b00;
        alu_op     = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = S_EXEC;
                if (dec_cls == C_ILL) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (cls_q)
                    C_ADD:  alu_op = 3'b000;
                    C_SUB:  alu_op = 3'b001;
                    C_AND:  alu_op = 3'b010;
                    C_ORR:  alu_op = 3'b011;
                    C_ADDI: alu_src = 1'b1;
                    C_SUBI: begin alu_src = 1'b1; alu_op = 3'b001; end
                    C_ANDI: begin alu_src = 1'b1; alu_op = 3'b010; end
                    C_ORRI: begin alu_src = 1'b1; alu_op = 3'b011; end
                    C_LDUR: begin alu_src = 1'b1; seu = 2'b01; state_d = S_MEM; end
                    C_STUR: begin
                        alu_src = 1'b1; seu = 2'b01; reg2loc = 1'b1; state_d = S_MEM;
                    end
                    C_B: begin seu = 2'b10; pc_src = 1'b1; pc_wr = 1'b1; state_d = S_FETCH; end
                    C_CBZ, C_CBNZ: begin
                        reg2loc = 1'b1;
                        seu     = 2'b11;
                        alu_op  = 3'b100;
                        pc_wr   = 1'b1;
                        pc_src  = (cls_q == C_CBZ) ? bus.zero : !bus.zero;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_rd = (cls_q == C_LDUR);
                mem_wr = (cls_q == C_STUR);
                if (bus.mem_ready) begin
                    if (cls_q == C_STUR) begin
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
                state_d    = S_FETCH;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            S_TRAP: illegal = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
        // While reset is held only the FETCH read request may be visible.
        if (reset) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            mem_err = 1'b0;
            illegal = 1'b0;
        end
        retired_d = retired_q + {{(RET_W-1){1'b0}}, pc_wr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc_wr      = pc_wr;
    assign bus.ir_wr      = ir_wr;
    assign bus.reg2loc    = reg2loc;
    assign bus.alu_src    = alu_src;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_wr     = reg_wr;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.pc_src     = pc_src;
    assign bus.seu        = seu;
    assign bus.alu_op     = alu_op;
    assign bus.state      = state_q;
    assign bus.mem_err    = mem_err;
    assign bus.retired    = retired_q;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal    = illegal;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif
endmodule
